fft_out_reader: RTL

//  Drains the final-stage results of the 8-point memory-based FFT from the two single-port data banks (BANK1/BANK0).

---
 rtl/fft_pkg.sv | 35 +++
 rtl/fft_out_fifo.sv | 66 ++++++
 rtl/fft_out_reader.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// ----------------------------------------------------------------------------
// fft_pkg
//  Shared definitions for the 8-point memory-based FFT datapath.
//  - N_PTS / LOG2N : transform length and its log2
//  - state_t       : output-reader FSM encodings
//  - bitrev3       : 3-bit bit reversal (natural k -> stored index j)
//  - bank_of       : bank holding stored index j (parity of j, 1 -> BANK1)
//  - bank_addr     : word address of j inside its bank (j >> 1)
// ----------------------------------------------------------------------------
package fft_pkg;

  localparam int N_PTS = 8;
  localparam int LOG2N = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic [2:0] bitrev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

  // Parity split keeps butterfly partners in opposite banks, so every
  // stage (and this final drain) can touch both banks without conflict.
  function automatic logic bank_of(input logic [2:0] j);
    return ^j;
  endfunction

  function automatic logic [1:0] bank_addr(input logic [2:0] j);
    return j[2:1];
  endfunction

endpackage

// File: rtl/fft_out_fifo.sv
// ----------------------------------------------------------------------------
// fft_out_fifo
//  Small synchronous FIFO used as the output skid buffer of fft_out_reader.
//  Storage, pointers and count are all flops; rdata is the head entry read
//  straight out of the register array, so it is stable while not popped.
//  Ports:
//   clk, rstn  clock, synchronous active-low reset (clears storage too)
//   push/wdata write one entry (ignored when full)
//   pop        drop head entry (ignored when empty)
//   rdata      head entry
//   empty      no entries held
//   count      number of entries held (0..DEPTH)
// ----------------------------------------------------------------------------
module fft_out_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, do_push, do_pop;

  // Wrap explicitly so non-power-of-two depths also work.
  function automatic logic [PTR_W-1:0] ptr_nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_nxt(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_nxt(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fft_out_reader.sv
// ----------------------------------------------------------------------------
// fft_out_reader
//  Drains the final-stage FFT results from the two single-port banks and
//  streams them out in natural order k = 0..7 on a valid/ready interface.
//  Ports:
//   clk, rstn               clock, synchronous active-low reset
//   start                   pulse: final stage fully written (IDLE only)
//   re_BANK1/0, addr_BANK1/0 bank read enables / addresses (one bank/cycle)
//   dout_BANK1/0            bank read data, one cycle after re
//   out_data/index/last     beat payload X[k], k, k==7
//   out_valid/out_ready     stream handshake
//   busy                    frame in progress (READ or DRAIN)
//   done                    one-cycle pulse after the k=7 handshake
//  Reads are only issued when the FIFO is guaranteed to have room for the
//  data coming back one cycle later, so the RAM pipeline never needs to stall.
// ----------------------------------------------------------------------------
module fft_out_reader
  import fft_pkg::*;
#(
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  output logic              re_BANK1,
  output logic              re_BANK0,
  output logic [ADDR_W-1:0] addr_BANK1,
  output logic [ADDR_W-1:0] addr_BANK0,
  input  logic [DATA_W-1:0] dout_BANK1,
  input  logic [DATA_W-1:0] dout_BANK0,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_index,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = DATA_W + LOG2N + 1;

  state_t             state;
  logic [LOG2N-1:0]   issue_k;   // next k to read
  logic               issue;
  logic [2:0]         j;
  logic               sel_bank;
  logic [ADDR_W-1:0]  sel_addr;

  // Tag pipeline travelling alongside the 1-cycle RAM latency.
  logic               inflight;
  logic               tag_bank;
  logic [LOG2N-1:0]   tag_k;

  logic [DATA_W-1:0]  cap_data;
  logic [ENT_W-1:0]   fifo_wdata, fifo_rdata;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               hs_last;

  assign j        = bitrev3(issue_k);
  assign sel_bank = bank_of(j);
  assign sel_addr = ADDR_W'(bank_addr(j));

  // Credit check on registered state only: a pop this cycle is not counted,
  // which costs nothing at full rate since count+inflight settles at 2.
  assign issue = (state == ST_READ) &&
                 ((int'(fifo_count) + int'(inflight)) < FIFO_DEPTH);

  assign re_BANK1   = issue &  sel_bank;
  assign re_BANK0   = issue & ~sel_bank;
  assign addr_BANK1 = re_BANK1 ? sel_addr : '0;
  assign addr_BANK0 = re_BANK0 ? sel_addr : '0;

  assign busy    = (state != ST_IDLE);
  assign hs_last = out_valid & out_ready & out_last;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      issue_k  <= '0;
      inflight <= 1'b0;
      tag_bank <= 1'b0;
      tag_k    <= '0;
      done     <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;
      if (issue) begin
        tag_bank <= sel_bank;
        tag_k    <= issue_k;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_READ;
            issue_k <= '0;
          end
        end
        ST_READ: begin
          if (issue) begin
            issue_k <= issue_k + LOG2N'(1);
            if (issue_k == LOG2N'(N_PTS - 1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (hs_last) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cap_data   = tag_bank ? dout_BANK1 : dout_BANK0;
  assign fifo_wdata = {cap_data, tag_k, (tag_k == LOG2N'(N_PTS - 1))};

  fft_out_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (inflight),
    .wdata (fifo_wdata),
    .pop   (out_ready),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_valid = ~fifo_empty;
  assign out_data  = fifo_rdata[ENT_W-1 -: DATA_W];
  assign out_index = fifo_rdata[LOG2N:1];
  assign out_last  = fifo_rdata[0];

endmodule
